// File: rtl/exe_mdu_ctrl.sv
// exe_mdu_ctrl -- multiply/divide sequencer that sits beside the EXE ALU.
// Owns the HI/LO registers. MULT/MULTU are latency-modelled: the product is
// formed when the op is accepted and committed after MUL_LAT cycles.
// DIV/DIVU run a 32-step restoring divider on operand magnitudes, and the
// signs are corrected on the commit edge. MTHI/MTLO write HI/LO directly
// and do not stall.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        EXE holds a valid MDU op (held with op/da/db while stall=1)
//   op[2:0]      0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   da, db       rs / rt operands
//   flush        abort any in-flight op; also cancels a pending commit
//   stall        hold PC/IF/ID/EXE this cycle
//   busy         sequencer is not idle
//   hi, lo       HI/LO architectural registers
module exe_mdu_ctrl #(
   parameter int MUL_LAT  = 2,
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] da,
   input  logic [31:0] db,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] prod;
   logic [31:0] rem, quo, dvsr;
   logic        neg_q, neg_r, res_div;

   // operand decode
   logic        op_mul, op_div, op_sdiv;
   logic [63:0] mul_a, mul_b, mul_p;
   logic [31:0] da_abs, db_abs;

   assign op_mul  = (op == OP_MULT) || (op == OP_MULTU);
   assign op_div  = (op == OP_DIV)  || (op == OP_DIVU);
   assign op_sdiv = (op == OP_DIV);

   // Sign-extend for MULT, zero-extend for MULTU; the low 64 bits of the
   // unsigned product are then the correct two's-complement result.
   assign mul_a = {{32{(op == OP_MULT) & da[31]}}, da};
   assign mul_b = {{32{(op == OP_MULT) & db[31]}}, db};
   assign mul_p = mul_a * mul_b;

   // Magnitudes for signed divide. -0x8000_0000 wraps to itself, which is
   // exactly 2^31 as an unsigned magnitude, so the overflow case needs no
   // special handling.
   assign da_abs = (op_sdiv && da[31]) ? (32'd0 - da) : da;
   assign db_abs = (op_sdiv && db[31]) ? (32'd0 - db) : db;

   // One restoring step: {rem,quo} shifted left, trial-subtract divisor.
   // 33 bits because the shifted remainder can exceed 32 bits for DIVU.
   logic [32:0] shifted, trial;
   assign shifted = {rem, quo[31]};
   assign trial   = shifted - {1'b0, dvsr};

   // Commit values with signed fix-up.
   logic [31:0] quo_fix, rem_fix, res_hi, res_lo;
   assign quo_fix = neg_q ? (32'd0 - quo) : quo;
   assign rem_fix = neg_r ? (32'd0 - rem) : rem;
   assign res_hi  = res_div ? rem_fix : prod[63:32];
   assign res_lo  = res_div ? quo_fix : prod[31:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         prod    <= '0;
         rem     <= '0;
         quo     <= '0;
         dvsr    <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         res_div <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               if (op_mul) begin
                  prod    <= mul_p;
                  res_div <= 1'b0;
                  cnt     <= 5'(MUL_LAT - 1);
                  state   <= S_MUL;
               end else if (op_div) begin
                  res_div <= 1'b1;
                  if (db == 32'd0) begin
                     // divide by zero: commit lo=all-ones, hi=da unchanged
                     rem   <= da;
                     quo   <= '1;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     rem   <= '0;
                     quo   <= da_abs;
                     dvsr  <= db_abs;
                     neg_q <= op_sdiv & (da[31] ^ db[31]);
                     neg_r <= op_sdiv & da[31];
                     cnt   <= 5'(DIV_ITER - 1);
                     state <= S_DIV;
                  end
               end else if (op == OP_MTHI) begin
                  hi <= da;
               end else if (op == OP_MTLO) begin
                  lo <= da;
               end
            end
            S_MUL: begin
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0) state <= S_DONE;
            end
            S_DIV: begin
               rem <= trial[32] ? shifted[31:0] : trial[31:0];
               quo <= {quo[30:0], ~trial[32]};
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0) state <= S_DONE;
            end
            S_DONE: begin
               hi    <= res_hi;
               lo    <= res_lo;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stall covers the accept cycle, so it must look at start/op directly.
   assign stall = !rst & (((state == S_IDLE) & start & (op_mul | op_div) & !flush)
                          | (state == S_MUL) | (state == S_DIV));
   assign busy  = !rst & (state != S_IDLE);

endmodule

// File: tb/tb_exe_mdu_ctrl.sv
module tb_exe_mdu_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  op;
   logic [31:0] da, db;
   logic        stall, busy;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   exe_mdu_ctrl #(.MUL_LAT(2), .DIV_ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .da(da), .db(db),
      .flush(flush), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, ehi, elo;
      int          est;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present an op, count stall cycles, let the commit edge pass, release.
   // Called and returns #1 after a posedge.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int nst);
      start = 1'b1; op = o; da = a; db = b; nst = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!stall) break;
         nst++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
   endtask

   initial begin
      int nst;

      tv[0]  = '{3'd1, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 3};
      tv[1]  = '{3'd2, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'hFFFF_FFFA, 3};
      tv[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      tv[3]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        33};
      tv[4]  = '{3'd4, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, 1};
      tv[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33};
      tv[6]  = '{3'd5, 32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5, 32'h8000_0000, 0};
      tv[7]  = '{3'd6, 32'h5A5A_5A5A, 32'h0,         32'hA5A5_A5A5, 32'h5A5A_5A5A, 0};
      tv[8]  = '{3'd1, 32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 3};
      tv[9]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 33};
      tv[10] = '{3'd3, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h2,         33};
      tv[11] = '{3'd4, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF, 33};
      tv[12] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
      tv[13] = '{3'd3, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
      tv[14] = '{3'd7, 32'h1234,      32'h5678,      32'hFFFF_FFFB, 32'hFFFF_FFFF, 0};
      tv[15] = '{3'd4, 32'd7,         32'd100,       32'd7,         32'd0,         33};

      // reset, with a DIV presented: stall must stay low while rst is high
      rst = 1'b1; start = 1'b1; op = 3'd3; da = 32'd9; db = 32'd2; flush = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst stall", stall, 0);
      chk("rst busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; op = 3'd0;
      @(negedge clk);
      chk("rst hi", hi, 0);
      chk("rst lo", lo, 0);
      chk("rst idle busy", busy, 0);
      @(posedge clk); #1;

      // table-driven ops
      for (int i = 0; i < 16; i++) begin
         run_op(tv[i].op, tv[i].a, tv[i].b, nst);
         chk($sformatf("v%0d stall cycles", i), nst, tv[i].est);
         chk($sformatf("v%0d hi", i), hi, tv[i].ehi);
         chk($sformatf("v%0d lo", i), lo, tv[i].elo);
         chk($sformatf("v%0d busy", i), busy, 0);
      end

      // flush at DIV iteration 11: back to IDLE, no write (hi=7, lo=0)
      start = 1'b1; op = 3'd3; da = 32'd100; db = 32'd3;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush div stall before", stall, 1);
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0; op = 3'd0;
      @(negedge clk);
      chk("flush div stall", stall, 0);
      chk("flush div busy", busy, 0);
      chk("flush div hi", hi, 32'd7);
      chk("flush div lo", lo, 32'd0);
      @(posedge clk); #1;

      // flush with start in IDLE: no stall, op never accepted
      start = 1'b1; op = 3'd1; da = 32'd5; db = 32'd5; flush = 1'b1;
      @(negedge clk);
      chk("flush idle stall", stall, 0);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0; flush = 1'b0;
      @(negedge clk);
      chk("flush idle busy", busy, 0);
      chk("flush idle hi", hi, 32'd7);
      chk("flush idle lo", lo, 32'd0);
      @(posedge clk); #1;

      // flush during DONE cancels the commit
      start = 1'b1; op = 3'd4; da = 32'd100; db = 32'd7; nst = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!stall) break;
         nst++;
         @(posedge clk); #1;
      end
      chk("flush done stall cycles", nst, 33);
      chk("flush done in done", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0; op = 3'd0;
      @(negedge clk);
      chk("flush done hi", hi, 32'd7);
      chk("flush done lo", lo, 32'd0);
      chk("flush done busy", busy, 0);
      @(posedge clk); #1;

      // back-to-back: MULT 6*7, then DIVU 50/5 presented the cycle after DONE
      run_op(3'd1, 32'd6, 32'd7, nst);
      chk("b2b mult stall cycles", nst, 3);
      chk("b2b mult hi", hi, 32'd0);
      chk("b2b mult lo", lo, 32'd42);
      run_op(3'd4, 32'd50, 32'd5, nst);
      chk("b2b div stall cycles", nst, 33);
      chk("b2b div hi", hi, 32'd0);
      chk("b2b div lo", lo, 32'd10);

      // reset mid-DIV
      start = 1'b1; op = 3'd4; da = 32'd100; db = 32'd7;
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst mid stall", stall, 0);
      chk("rst mid busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; op = 3'd0;
      @(negedge clk);
      chk("rst mid hi", hi, 32'd0);
      chk("rst mid lo", lo, 32'd0);
      chk("rst mid busy after", busy, 0);
      chk("rst mid stall after", stall, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
